// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the MMIO controller: region select, register map,
// TX buffer state encoding and the decoded-access struct.
package mmio_ctrl_pkg;
  localparam logic [1:0] IO_REGION_DEF = 2'b10;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] off;
  } mmio_req_t;

  // Accesses outside the IO region are squashed here so nothing downstream acts on them.
  function automatic mmio_req_t decode(input logic [31:0] addr, input logic we,
                                       input logic re, input logic [1:0] region);
    mmio_req_t r;
    r.rd  = re && (addr[31:30] == region);
    r.wr  = we && (addr[31:30] == region);
    r.off = addr[7:0];
    return r;
  endfunction
endpackage

// File: rtl/mmio_ctrl_if.sv
// Load/store port between the pipeline's memory stage and the MMIO block.
interface mmio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/mmio_ctrl_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  // Clear has priority so a clear on an active cycle still lands at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped IO block: UART RX/TX registers plus cycle and retired-instruction
// counters, read back with one cycle of latency.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int         CNT_W     = 32,
  parameter logic [1:0] IO_REGION = IO_REGION_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  mmio_ctrl_if.slave  bus,
  input  logic        instr_valid,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ready,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready
);
  mmio_req_t        req;
  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       tx_data_d;
  logic [31:0]      rd_val, rdata_q;
  logic [CNT_W-1:0] cyc_cnt, instr_cnt;
  logic             cnt_clr, tx_free;

  assign req     = decode(bus.addr, bus.we, bus.re, IO_REGION);
  assign cnt_clr = req.wr && (req.off == OFF_CLR);
  assign tx_free = (tx_state_q == TX_IDLE);

  perf_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(rst_n), .inc(1'b1), .clr(cnt_clr), .cnt(cyc_cnt)
  );
  perf_counter #(.CNT_W(CNT_W)) u_instr (
    .clk(clk), .rst_n(rst_n), .inc(instr_valid), .clr(cnt_clr), .cnt(instr_cnt)
  );

  always_comb begin
    rd_val = '0;
    case (req.off)
      OFF_STATUS: rd_val = {30'b0, uart_rx_valid, tx_free};
      OFF_RX:     rd_val = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
      OFF_CYC:    rd_val = 32'(cyc_cnt);
      OFF_INSTR:  rd_val = 32'(instr_cnt);
      default:    rd_val = '0;
    endcase
  end

  // rdata only moves on a load; an out-of-region load returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q       <= '0;
      uart_rx_ready <= 1'b0;
    end else begin
      if (bus.re) rdata_q <= req.rd ? rd_val : 32'b0;
      uart_rx_ready <= req.rd && (req.off == OFF_RX) && uart_rx_valid;
    end
  end

  assign bus.rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      uart_tx_data <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      uart_tx_data <= tx_data_d;
    end
  end

  // A store to the TX register while a byte is pending is dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = uart_tx_data;
    case (tx_state_q)
      TX_IDLE: if (req.wr && (req.off == OFF_TX)) begin
        tx_state_d = TX_PEND;
        tx_data_d  = bus.wdata[7:0];
      end
      TX_PEND: if (uart_tx_ready) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_tx_valid = (tx_state_q == TX_PEND);
endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of both performance counters.
REQ-002 SHALL have parameter IO_REGION, default 2'b10, the value of addr[31:30] that selects this block.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  stage-3 data address.
REQ-006 wdata  input  32  store data.
REQ-007 we  input  1  store issued this cycle.
REQ-008 re  input  1  load issued this cycle.
REQ-009 instr_valid  input  1  one non-bubble instruction retired this cycle.
REQ-010 rdata  output  32  registered load data.
REQ-011 uart_rx_valid  input  1  UART receiver holds a byte.
REQ-012 uart_rx_data  input  8  received byte.
REQ-013 uart_rx_ready  output  1  consume-byte strobe to the receiver.
REQ-014 uart_tx_valid  output  1  transmit byte pending.
REQ-015 uart_tx_data  output  8  byte to transmit.
REQ-016 uart_tx_ready  input  1  transmitter accepts a byte.

Function
REQ-017 The block SHALL act only when addr[31:30]==IO_REGION; otherwise we/re SHALL be ignored and rdata SHALL be 0 on the following cycle.
REQ-018 Map (addr[7:0]): 0x00 R status {30'b0, uart_rx_valid, tx_free}; 0x04 R rx byte {24'b0, byte}; 0x08 W tx byte wdata[7:0]; 0x10 R cycle counter; 0x14 R instruction counter; 0x18 W counter clear (any data).
REQ-019 Reads SHALL have one-cycle latency: rdata registered on the edge after re, held until the next re.
REQ-020 Reads of unmapped offsets and writes to unmapped/read-only offsets SHALL return 0 / have no effect.
REQ-021 A read of 0x04 with uart_rx_valid=1 SHALL capture uart_rx_data into rdata and assert uart_rx_ready for exactly that one cycle.
REQ-022 A read of 0x04 with uart_rx_valid=0 SHALL return 0 and not assert uart_rx_ready.
REQ-023 TX SHALL be a one-entry buffer, states IDLE and PEND; tx_free=1 only in IDLE.
REQ-024 IDLE->PEND on a write to 0x08, latching wdata[7:0] into uart_tx_data; uart_tx_valid=1 in PEND.
REQ-025 PEND->IDLE on the edge where uart_tx_valid && uart_tx_ready.
REQ-026 A write to 0x08 in PEND SHALL be dropped; the buffered byte SHALL remain unchanged.
REQ-027 The cycle counter SHALL increment every cycle; the instruction counter SHALL increment on each cycle with instr_valid=1.
REQ-028 Both counters SHALL wrap modulo 2^CNT_W without a flag.
REQ-029 A write to 0x18 SHALL load both counters with 0 on that edge; clear SHALL win over a simultaneous increment.
REQ-030 we and re asserted together SHALL perform both operations independently.

Reset
REQ-031 While rst_n=0: rdata=0, uart_rx_ready=0, uart_tx_valid=0, uart_tx_data=0, TX state IDLE, both counters 0.
REQ-032 Reset asserted mid-PEND SHALL discard the pending byte immediately and asynchronously.
REQ-033 The first increment after reset SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-034 Register offsets, IO_REGION and the TX state encoding SHALL live in the shared riscv package next to the opcode defines.
REQ-035 Counters SHALL be one sub-module, perf_counter, instantiated twice with inc and clr inputs.

Verification
REQ-036 Reset release, idle 10 cycles, load 0x80000010 -> rdata=10 (±1 read latency, exact value checked against model).
REQ-037 uart_rx_valid=1, uart_rx_data=0x5A, load 0x80000004 -> next cycle rdata=0x0000005A, uart_rx_ready high for one cycle only.
REQ-038 uart_tx_ready=0, store 0x41 to 0x80000008, then store 0x42 -> uart_tx_data stays 0x41, status reads 0x0; raise uart_tx_ready -> one handshake, status bit0=1.
REQ-039 Preload cycle counter near 0xFFFFFFFF (force), run 3 cycles -> value wraps to 0x00000001-range per model, no glitch.
REQ-040 Store to 0x80000018 while instr_valid=1 -> both counters read 0 on next access, not 1 for instruction counter.
REQ-041 Assert rst_n=0 during PEND between edges -> uart_tx_valid falls immediately; load 0x40000000 returns 0 and causes no side effects.
